// File: rtl/tb_scheduler_if.sv
// tb_scheduler_if: memory-side and readout-side handshake bundle for the transpose scheduler
interface tb_scheduler_if #(
  parameter int CW = 2,
  parameter int RW = 2
);
  logic          mem_valid;
  logic          mem_ready;
  logic          wr_en;
  logic          wr_bank;
  logic [RW-1:0] wr_row;
  logic          out_ready;
  logic          out_valid;
  logic          rd_en;
  logic          rd_bank;
  logic [CW-1:0] rd_col;
  logic [1:0]    status;
  logic [15:0]   pass_count;
  modport master (
    output mem_valid, out_ready,
    input  mem_ready, wr_en, wr_bank, wr_row, out_valid, rd_en, rd_bank, rd_col, status, pass_count
  );
  modport slave (
    input  mem_valid, out_ready,
    output mem_ready, wr_en, wr_bank, wr_row, out_valid, rd_en, rd_bank, rd_col, status, pass_count
  );
endinterface

// File: rtl/tb_scheduler.sv
// tb_scheduler: ping-pong transpose buffer sequencer issuing row writes and column reads
module tb_scheduler #(
  parameter int FETCH_WIDTH = 4,
  parameter int TB_HEIGHT = 4,
  localparam int CW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
  localparam int RW = (TB_HEIGHT > 1) ? $clog2(TB_HEIGHT) : 1
) (
  input logic clk,
  input logic rst,
  input logic flush,
  tb_scheduler_if.slave bus
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, BOTH = 2'd2} state_t;
  localparam logic [RW-1:0] ROW_LAST = RW'(TB_HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(FETCH_WIDTH - 1);
  state_t state, state_d;
  logic [1:0] full;
  logic wr_bank, rd_bank, wr_en, rd_en, clr, fill_done, drain_done;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] rd_col;
  logic [15:0] pass_count;
  assign clr = rst | flush;
  assign bus.mem_ready = ~full[wr_bank] & ~clr;
  assign bus.out_valid = full[rd_bank] & ~clr;
  assign wr_en = bus.mem_valid & bus.mem_ready;
  assign rd_en = bus.out_ready & bus.out_valid;
  assign fill_done = wr_en & (wr_row == ROW_LAST);
  assign drain_done = rd_en & (rd_col == COL_LAST);
  assign bus.wr_en = wr_en;
  assign bus.rd_en = rd_en;
  assign bus.wr_bank = wr_bank;
  assign bus.wr_row = wr_row;
  assign bus.rd_bank = rd_bank;
  assign bus.rd_col = rd_col;
  assign bus.status = state;
  assign bus.pass_count = pass_count;
  // occupancy next state; a fill and a drain completing together cancel out
  always_comb begin
    state_d = state;
    case (state)
      EMPTY: state_d = fill_done ? ONE : EMPTY;
      ONE:   state_d = (fill_done && !drain_done) ? BOTH : (drain_done && !fill_done) ? EMPTY : ONE;
      BOTH:  state_d = drain_done ? ONE : BOTH;
      default: state_d = EMPTY;
    endcase
  end
  // occupancy register
  always_ff @(posedge clk) begin
    if (clr) state <= EMPTY;
    else state <= state_d;
  end
  // per-bank full flags; fill and drain always hit different banks
  always_ff @(posedge clk) begin
    if (clr) begin
      full <= '0;
    end else begin
      if (fill_done) full[wr_bank] <= 1'b1;
      if (drain_done) full[rd_bank] <= 1'b0;
    end
  end
  // write cursor: row index, bank toggles when a bank is completed
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_row <= '0;
      wr_bank <= 1'b0;
    end else if (wr_en) begin
      wr_row <= (wr_row == ROW_LAST) ? '0 : wr_row + 1'b1;
      wr_bank <= (wr_row == ROW_LAST) ? ~wr_bank : wr_bank;
    end
  end
  // read cursor: column index, bank toggles when a bank is drained
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_col <= '0;
      rd_bank <= 1'b0;
    end else if (rd_en) begin
      rd_col <= (rd_col == COL_LAST) ? '0 : rd_col + 1'b1;
      rd_bank <= (rd_col == COL_LAST) ? ~rd_bank : rd_bank;
    end
  end
  // drained-bank counter survives flush, cleared only by rst
  always_ff @(posedge clk) begin
    if (rst) pass_count <= '0;
    else if (drain_done) pass_count <= pass_count + 1'b1;
  end
endmodule

// File: tb/tb_tb_scheduler.sv
// tb_tb_scheduler: randomized scoreboard bench for tb_scheduler against a row/column counting model
module tb_tb_scheduler;
  localparam int FW = 4;
  localparam int H = 4;
  localparam int CW = (FW > 1) ? $clog2(FW) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  typedef struct packed {
    logic       mem_ready;
    logic       out_valid;
    logic [1:0] status;
    logic [15:0] pass;
    logic       wr_bank;
    logic [7:0] wr_row;
    logic       rd_bank;
    logic [7:0] rd_col;
  } snap_t;
  typedef struct packed {
    logic       bank;
    logic [7:0] idx;
  } xfer_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int rows = 0;
  int cols = 0;
  logic [15:0] passes = '0;
  snap_t sq[$];
  xfer_t wq[$];
  xfer_t rq[$];
  tb_scheduler_if #(.CW(CW), .RW(RW)) bus ();
  tb_scheduler #(.FETCH_WIDTH(FW), .TB_HEIGHT(H)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // one cycle: drive inputs after the edge, record what the model says this cycle must show
  task automatic step(input logic r, input logic fl, input logic mv, input logic orr);
    snap_t s;
    xfer_t x;
    int nfull;
    logic clr, rdy, vld;
    @(posedge clk);
    #1;
    rst = r;
    flush = fl;
    bus.mem_valid = mv;
    bus.out_ready = orr;
    clr = r | fl;
    nfull = rows / H - cols / FW;
    rdy = !clr && nfull < 2;
    vld = !clr && nfull > 0;
    s.mem_ready = rdy;
    s.out_valid = vld;
    s.status = 2'(nfull);
    s.pass = passes;
    s.wr_bank = 1'((rows / H) % 2);
    s.wr_row = 8'(rows % H);
    s.rd_bank = 1'((cols / FW) % 2);
    s.rd_col = 8'(cols % FW);
    sq.push_back(s);
    if (mv && rdy) begin
      x.bank = s.wr_bank;
      x.idx = s.wr_row;
      wq.push_back(x);
      rows++;
    end
    if (orr && vld) begin
      x.bank = s.rd_bank;
      x.idx = s.rd_col;
      rq.push_back(x);
      cols++;
      if (cols % FW == 0) passes++;
    end
    if (clr) begin
      rows = 0;
      cols = 0;
      if (r) passes = '0;
    end
  endtask
  // monitor: checks state every cycle and pops a transfer whenever the DUT strobes one
  always @(negedge clk) begin
    snap_t s;
    xfer_t x;
    if (sq.size() != 0) begin
      s = sq.pop_front();
      chk("mem_ready", int'(bus.mem_ready), int'(s.mem_ready));
      chk("out_valid", int'(bus.out_valid), int'(s.out_valid));
      chk("status", int'(bus.status), int'(s.status));
      chk("pass_count", int'(bus.pass_count), int'(s.pass));
      chk("wr_bank", int'(bus.wr_bank), int'(s.wr_bank));
      chk("wr_row", int'(bus.wr_row), int'(s.wr_row));
      chk("rd_bank", int'(bus.rd_bank), int'(s.rd_bank));
      chk("rd_col", int'(bus.rd_col), int'(s.rd_col));
      if (bus.wr_en) begin
        if (wq.size() == 0) chk("unexpected_wr_en", 1, 0);
        else begin
          x = wq.pop_front();
          chk("wr_xfer_bank", int'(bus.wr_bank), int'(x.bank));
          chk("wr_xfer_row", int'(bus.wr_row), int'(x.idx));
        end
      end else if (wq.size() != 0) begin
        x = wq.pop_front();
        chk("missing_wr_en", 0, 1);
      end
      if (bus.rd_en) begin
        if (rq.size() == 0) chk("unexpected_rd_en", 1, 0);
        else begin
          x = rq.pop_front();
          chk("rd_xfer_bank", int'(bus.rd_bank), int'(x.bank));
          chk("rd_xfer_col", int'(bus.rd_col), int'(x.idx));
        end
      end else if (rq.size() != 0) begin
        x = rq.pop_front();
        chk("missing_rd_en", 0, 1);
      end
    end
  end
  initial begin
    bus.mem_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) step(1, 0, 0, 0);
    repeat (4) step(0, 0, 1, 0);
    repeat (4) step(0, 0, 1, 0);
    repeat (3) step(0, 0, 1, 0);
    repeat (4) step(0, 0, 1, 1);
    repeat (24) step(0, 0, 1, 1);
    repeat (12) step(0, 0, 0, 1'($urandom_range(0, 1)));
    repeat (20) step(0, 0, 1, 1'($urandom_range(0, 1)));
    while (passes % 16'd8 != 16'd5 || rows % H != 2 || rows / H - cols / FW != 1)
      step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(0, 1, 1, 1);
    repeat (3) step(0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      step(($urandom % 700) == 0, ($urandom % 150) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0);
    repeat (6) step(0, 0, 1, 1);
    @(negedge clk);
    #1;
    chk("queues_drained", sq.size() + wq.size() + rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tb_scheduler.md
# tb_scheduler

Sequencing controller for a double-buffered (ping-pong) transpose buffer. It accepts row words from memory into one bank while the other bank is read out column by column. It generates the bank select and row/column indices that the transpose buffer datapath consumes, and applies valid/ready back-pressure on both sides. It sits between the memory read port and the transpose buffer storage, and owns the bank switch decision.

## Interface
Parameters:
- FETCH_WIDTH, default 4: words per memory row, which equals the number of columns read out per bank.
- TB_HEIGHT, default 4: rows stored per bank.
- Derived: CW = max(1, clog2(FETCH_WIDTH)); RW = max(1, clog2(TB_HEIGHT)).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all sequencing state; same effect as rst; rst has priority.
- mem_valid  in  1  memory presents a row word this cycle.
- mem_ready  out  1  scheduler accepts a row this cycle.
- wr_en  out  1  write strobe to the transpose buffer; equals mem_valid & mem_ready.
- wr_bank  out  1  bank being filled.
- wr_row  out  RW  row index for the current write.
- out_ready  in  1  downstream accepts a column this cycle.
- out_valid  out  1  a column is available.
- rd_en  out  1  read strobe; equals out_valid & out_ready.
- rd_bank  out  1  bank being drained.
- rd_col  out  CW  column index for the current read.
- status  out  2  occupancy: 0 = both banks empty, 1 = exactly one bank full, 2 = both banks full; 3 never occurs.
- pass_count  out  16  number of banks fully drained since reset; wraps modulo 2^16.

## Operation
Registered state:
- full[1:0]
- wr_bank, wr_row
- rd_bank, rd_col
- pass_count

Write side:
- mem_ready = ~full[wr_bank] & ~rst & ~flush.
- When wr_en is high and wr_row < TB_HEIGHT-1, wr_row increments.
- When wr_en is high and wr_row == TB_HEIGHT-1:
  - wr_row wraps to 0.
  - full[wr_bank] is set.
  - wr_bank toggles.

Read side:
- out_valid = full[rd_bank] & ~rst & ~flush.
- When rd_en is high and rd_col < FETCH_WIDTH-1, rd_col increments.
- When rd_en is high and rd_col == FETCH_WIDTH-1:
  - rd_col wraps to 0.
  - full[rd_bank] is cleared.
  - rd_bank toggles.
  - pass_count increments.

Occupancy state machine (status), with transitions:
- EMPTY (0):
  - Goes to ONE when a fill completes.
- ONE (1):
  - Goes to BOTH on fill completion without drain completion.
  - Goes to EMPTY on drain completion without fill completion.
  - Stays in ONE when both complete in the same cycle.
- BOTH (2):
  - Goes to ONE on drain completion.
  - Fill completion is impossible here because mem_ready = 0.

Simultaneous events and invariants:
- Fill and drain completion in the same cycle always target different banks. Both updates take effect in that cycle.
- The writer never targets a full bank, and the reader never targets an empty bank.
- A bank is never both written and read in the same cycle.
- rd_bank == wr_bank whenever status is 0 or 2.

Back-pressure:
- mem_valid low holds the write state.
- out_ready low holds the read state.
- Indices and bank selects stay stable while stalled.
- Index outputs are driven even when the strobe is low; downstream qualifies them with wr_en or rd_en.

Reset and flush:
- Reset values: full = 0, wr_bank = 0, wr_row = 0, rd_bank = 0, rd_col = 0, pass_count = 0.
- Resulting outputs: status = 0, out_valid = 0, rd_en = 0, wr_en = 0.
- mem_ready = 0 during the rst/flush cycle and 1 from the following cycle.
- Mid-operation rst or flush discards partial fills and drains; contents of the storage are ignored.
- flush does not clear pass_count; rst does.

## Timing
- Strobes and valid/ready outputs are combinational from registered state plus the handshake inputs. There is no combinational path from mem_valid to out_valid.
- Fill-to-read latency: out_valid rises in the cycle after the wr_en that completes the bank.
- Drain-to-write latency: mem_ready rises in the cycle after the rd_en that empties the bank, if the writer was blocked.
- Steady state with both sides always asserted and FETCH_WIDTH == TB_HEIGHT: one write and one read every cycle, no bubbles after the first bank fill.
- First column is available TB_HEIGHT+1 cycles after the first accepted row, counting from the first wr_en cycle as cycle 1.

## Test plan
1. Reset and fill, FW = 4, H = 4:
   - Stimulus: rst for 2 cycles, then mem_valid = 1 for 4 cycles, out_ready = 0.
   - Response: wr_row = 0, 1, 2, 3 with wr_bank = 0. Next cycle: status = 1, out_valid = 1, mem_ready = 1, wr_bank = 1.
2. Both banks full:
   - Stimulus: continue case 1 with 4 more writes.
   - Response: status = 2, mem_ready = 0. Further mem_valid produces no wr_en, and wr_row holds 0.
3. Drain with overlap:
   - Stimulus: from case 2, out_ready = 1 for 4 cycles.
   - Response: rd_col = 0, 1, 2, 3 on rd_bank 0. Next cycle: rd_bank = 1, pass_count = 1, status = 1, mem_ready = 1.
4. Simultaneous completion:
   - Stimulus: mem_valid = 1 and out_ready = 1 continuously after the first fill.
   - Response: wr_en and rd_en are high every cycle, status stays at 1, and pass_count increments every 4 cycles.
5. Stall stability:
   - Stimulus: toggle out_ready pseudo-randomly during a drain.
   - Response: rd_col advances only on rd_en, and the column sequence 0..3 has no skips or repeats.
6. Flush mid-fill:
   - Stimulus: flush with wr_row = 2, status = 1, pass_count = 5.
   - Response: next cycle all counters are 0 except pass_count, which stays 5; status = 0; out_valid = 0.
